// File: rtl/led_animator_if.sv
// Score-display LED bus: trigger/abort requests from scoring logic, LED pattern and status back.
interface led_animator_if #(parameter int LED_WIDTH = 8);
  logic                 goal_player_1;
  logic                 goal_player_2;
  logic                 win_player_1;
  logic                 win_player_2;
  logic                 abort;
  logic [LED_WIDTH-1:0] led;
  logic                 busy;
  logic                 done;

  modport master (
    output goal_player_1, goal_player_2, win_player_1, win_player_2, abort,
    input  led, busy, done
  );

  modport slave (
    input  goal_player_1, goal_player_2, win_player_1, win_player_2, abort,
    output led, busy, done
  );
endinterface

// File: rtl/led_animator.sv
// Goal/win LED animation sequencer: prioritised triggers, win pre-emption, abort, busy/done status.
module led_animator #(
    parameter int LED_WIDTH  = 8,
    parameter int STEP_TICKS = 3,
    parameter int GOAL_REPS  = 1,
    parameter int WIN_REPS   = 1,
    parameter int HOLD_TICKS = 4
) (
    input logic           BALL_CLOCK,
    input logic           reset_n,
    led_animator_if.slave bus
);
    localparam int H        = LED_WIDTH / 2;
    localparam int FRAME_W  = $clog2(LED_WIDTH);
    localparam int TICK_MAX = (STEP_TICKS > HOLD_TICKS) ? STEP_TICKS : HOLD_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);
    localparam int REP_MAX  = (GOAL_REPS > WIN_REPS) ? GOAL_REPS : WIN_REPS;
    localparam int REP_W    = $clog2(REP_MAX + 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_e;
    typedef enum logic [1:0] {GOAL1, GOAL2, WIN1, WIN2} mode_e;

    state_e               state, state_n;
    mode_e                mode, mode_n, start_mode;
    logic [FRAME_W-1:0]   frame, frame_n;
    logic [TICK_W-1:0]    tick, tick_n, tick_end;
    logic [REP_W-1:0]     rep, rep_n;
    logic [LED_WIDTH-1:0] led_n;
    logic                 done_n, start, is_win, last_frame, win_req;

    function automatic logic [LED_WIDTH-1:0] frame_pattern(input mode_e m, input logic [FRAME_W-1:0] fr);
        logic [LED_WIDTH-1:0] p;
        int f, j;
        p = '0;
        f = int'(fr);
        j = f - H + 1;
        for (int i = 0; i < LED_WIDTH; i++) begin
            case (m)
                GOAL1:   p[i] = (i == LED_WIDTH - 1 - f);
                GOAL2:   p[i] = (i == f);
                WIN1:    p[i] = (f < H) ? ((i == f) || (i == LED_WIDTH - 1 - f))
                                        : ((i >= H - 1) && (i <= H + j));
                default: p[i] = (f < H) ? ((i == f) || (i == LED_WIDTH - 1 - f))
                                        : ((i >= H - 1 - j) && (i <= H));
            endcase
        end
        return p;
    endfunction

    assign is_win     = (mode == WIN1) || (mode == WIN2);
    // A win sequence has W-1 frames (H converge + H-1 fill); a goal sweep has W.
    assign last_frame = is_win ? (frame == FRAME_W'(LED_WIDTH - 2)) : (frame == FRAME_W'(LED_WIDTH - 1));
    assign tick_end   = (state == RUN && is_win && last_frame) ? TICK_W'(HOLD_TICKS - 1)
                                                               : TICK_W'(STEP_TICKS - 1);
    assign win_req    = bus.win_player_1 || bus.win_player_2;

    always_comb begin
        state_n    = state;
        mode_n     = mode;
        frame_n    = frame;
        tick_n     = tick;
        rep_n      = rep;
        done_n     = 1'b0;
        start      = 1'b0;
        start_mode = bus.win_player_1 ? WIN1 : WIN2;
        if (bus.abort) begin
            state_n = IDLE;
            frame_n = '0;
            tick_n  = '0;
            rep_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_req) begin
                        start = 1'b1;
                    end else if (bus.goal_player_1) begin
                        start      = 1'b1;
                        start_mode = GOAL1;
                    end else if (bus.goal_player_2) begin
                        start      = 1'b1;
                        start_mode = GOAL2;
                    end
                end
                RUN, GAP: begin
                    if (win_req && !is_win) begin
                        start = 1'b1;
                    end else if (tick != tick_end) begin
                        tick_n = tick + 1'b1;
                    end else if (state == GAP) begin
                        state_n = RUN;
                        frame_n = '0;
                        tick_n  = '0;
                    end else if (!last_frame) begin
                        frame_n = frame + 1'b1;
                        tick_n  = '0;
                    end else if (rep <= REP_W'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        frame_n = '0;
                        tick_n  = '0;
                        rep_n   = '0;
                    end else begin
                        state_n = GAP;
                        tick_n  = '0;
                        rep_n   = rep - 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        if (start) begin
            state_n = RUN;
            mode_n  = start_mode;
            frame_n = '0;
            tick_n  = '0;
            rep_n   = (start_mode == WIN1 || start_mode == WIN2) ? REP_W'(WIN_REPS) : REP_W'(GOAL_REPS);
        end
        led_n = (state_n == RUN) ? frame_pattern(mode_n, frame_n) : '0;
    end

    always_ff @(posedge BALL_CLOCK) begin
        if (!reset_n) begin
            state    <= IDLE;
            mode     <= GOAL1;
            frame    <= '0;
            tick     <= '0;
            rep      <= '0;
            bus.led  <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state    <= state_n;
            mode     <= mode_n;
            frame    <= frame_n;
            tick     <= tick_n;
            rep      <= rep_n;
            bus.led  <= led_n;
            bus.busy <= (state_n != IDLE);
            bus.done <= done_n;
        end
    end
endmodule

// File: doc/led_animator.md
# led_animator

Parametrised LED animation sequencer for the score display. It generalises the fixed 8-LED goal/win animations to any even LED count, with configurable frame duration, repetition counts and final-frame hold. It adds explicit trigger priority, win pre-emption, abort, and `busy`/`done` status. It sits between the scoring logic (goal/win pulses) and the board LED pins and is clocked by the ball clock.

## Interface
- `LED_WIDTH`, 8: number of LEDs; even, ≥4.
- `STEP_TICKS`, 3: clock cycles each frame is shown; ≥1.
- `GOAL_REPS`, 1: sweep repetitions per goal animation; ≥1.
- `WIN_REPS`, 1: repetitions per win animation; ≥1.
- `HOLD_TICKS`, 4: cycles the final win frame is held; ≥1.
- `BALL_CLOCK` in 1: single clock. All logic is on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `goal_player_1` in 1: request the goal-1 animation (sampled each cycle).
- `goal_player_2` in 1: request the goal-2 animation.
- `win_player_1` in 1: request the win-1 animation.
- `win_player_2` in 1: request the win-2 animation.
- `abort` in 1: stop any animation immediately.
- `led` out LED_WIDTH: registered LED pattern. Bit LED_WIDTH-1 is the leftmost LED.
- `busy` out 1: an animation is running.
- `done` out 1: one-cycle pulse on natural completion.

## Operation
- States: IDLE, RUN, GAP.
  - RUN shows frames.
  - GAP is one blank frame (`led`=0 for STEP_TICKS cycles) between repetitions.
- The mode register holds GOAL1, GOAL2, WIN1 or WIN2. A frame index, a tick counter and a repetition counter are sized by clog2 of their maxima.
- Frame sequences, with W=LED_WIDTH and H=W/2:
  - GOAL1: W one-hot frames, from bit W-1 down to bit 0.
  - GOAL2: W one-hot frames, from bit 0 up to bit W-1.
  - WIN1, converge phase: H frames; frame k sets bits k and W-1-k.
  - WIN1, fill phase: H-1 frames; frame j sets bits [H+j : H-1], for j=1..H-1. The last frame is bits [W-1:H-1].
  - WIN2: the converge phase is the same as WIN1. The fill phase is mirrored: bits [H : H-1-j], for j=1..H-1.
- Frame durations:
  - Every frame lasts STEP_TICKS cycles.
  - Exception: the last frame of each WIN repetition lasts HOLD_TICKS cycles.
- Trigger acceptance in IDLE:
  - Fixed priority win_player_1 > win_player_2 > goal_player_1 > goal_player_2.
  - Lower-priority requests in the same cycle are dropped.
  - The repetition counter loads GOAL_REPS or WIN_REPS.
- Triggers while busy:
  - A win request during a GOAL animation pre-empts it. The win animation restarts from its first frame, the repetition count reloads, and no `done` is issued for the goal.
  - Goal requests while busy are ignored.
  - Win requests during a WIN animation are ignored.
- Completion:
  - After the last frame of the last repetition, return to IDLE with `led`=0.
  - `done`=1 for exactly that one cycle.
- `abort` behaviour:
  - On the next edge: IDLE, `led`=0, `busy`=0, `done`=0.
  - `abort` wins over any trigger in the same cycle; that trigger is lost.
  - `abort` in IDLE has no effect.
- Reset: `led`=0, `busy`=0, `done`=0, state IDLE, all counters 0. Reset dominates `abort` and all triggers.

## Timing
- Trigger sampled at edge t: the first frame appears on `led` at t+1, and `busy`=1 from t+1.
- Pre-emption sampled at edge t: the first win frame appears at t+1, with no blank cycle.
- GOAL duration (`busy` high): R·W·STEP_TICKS + (R-1)·STEP_TICKS cycles, with R=GOAL_REPS.
- WIN duration (`busy` high): R·((W-2)·STEP_TICKS + HOLD_TICKS) + (R-1)·STEP_TICKS cycles, with R=WIN_REPS.
- Completion cycle: `done`=1, `busy`=0 and `led`=0 together. The next trigger can be accepted on that same edge, so its first frame appears one cycle later.
- `busy` and `done` are never high together.

## Test plan
All scenarios use defaults W=8, STEP_TICKS=3, reps=1, HOLD_TICKS=4, with the trigger pulsed at cycle 0.
- goal_player_1:
  - `led` = 0x80 for cycles 1–3, 0x40 for 4–6, … 0x01 for 22–24.
  - Cycle 25: `led`=0, `done`=1, `busy`=0. `busy`=1 for cycles 1–24.
- goal_player_2: `led` = 0x01, 0x02, … 0x80 with the same timing; `done` at cycle 25.
- win_player_1:
  - `led` = 0x81, 0x42, 0x24, 0x18, 0x38, 0x78, each for 3 cycles (cycles 1–18).
  - Then 0xF8 for cycles 19–22.
  - Cycle 23: `done`=1.
- win_player_2:
  - `led` = 0x81, 0x42, 0x24, 0x18, 0x1C, 0x1E (cycles 1–18).
  - Then 0x1F for cycles 19–22; `done` at cycle 23.
- Priority and pre-emption:
  - All four triggers at cycle 0 → WIN1 runs (0x81 at cycle 1).
  - goal_player_1 at cycle 0, then win_player_2 at cycle 5 → `led`=0x81 at cycle 6, no `done` until cycle 28.
  - goal_player_2 at cycle 5 during WIN → ignored.
- Abort, reset and repetitions:
  - `abort` at cycle 10 during GOAL1 → cycle 11: `led`=0, `busy`=0, `done`=0.
  - `reset_n`=0 at cycle 10 → same result.
  - With GOAL_REPS=2: blank frame at cycles 25–27, second sweep 28–51, `done` at cycle 52.
